// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and default widths for the memory-stage controller.
package mem_stage_ctrl_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    HALT   = 2'b10
  } state_e;

endpackage

// File: rtl/mem_stage_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register: loads a retiring instruction, or inserts a bubble
// that clears the control bits while the data fields keep their last value.
module mem_wb_reg #(
  parameter int unsigned DATA_W = mem_stage_ctrl_pkg::DATA_W,
  parameter int unsigned SEL_W  = mem_stage_ctrl_pkg::SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bubble,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] next_pc,
  input  logic [SEL_W-1:0]  reg_sel,
  input  logic              reg_write,
  input  logic              jr,
  input  logic              dump,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] wb_nextPC,
  output logic [SEL_W-1:0]  wb_reg_sel,
  output logic              wb_reg_write,
  output logic              wb_jr,
  output logic              wb_dump
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data      <= '0;
      wb_nextPC    <= '0;
      wb_reg_sel   <= '0;
      wb_reg_write <= 1'b0;
      wb_jr        <= 1'b0;
      wb_dump      <= 1'b0;
    end else if (bubble) begin
      wb_reg_write <= 1'b0;
      wb_jr        <= 1'b0;
      wb_dump      <= 1'b0;
    end else begin
      wb_data      <= data;
      wb_nextPC    <= next_pc;
      wb_reg_sel   <= reg_sel;
      wb_reg_write <= reg_write;
      wb_jr        <= jr;
      wb_dump      <= dump;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage controller: issues data-memory accesses from EX/MEM, stalls the
// pipeline while an access is outstanding and fills MEM/WB on retirement.
module mem_stage_ctrl #(
  parameter int unsigned DATA_W  = mem_stage_ctrl_pkg::DATA_W,
  parameter int unsigned SEL_W   = mem_stage_ctrl_pkg::SEL_W,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jr_in,
  input  logic              mem_to_reg_in,
  input  logic              mem_write_in,
  input  logic              reg_write_in,
  input  logic              dump_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] B_in,
  input  logic [DATA_W-1:0] nextPC_in,
  input  logic [SEL_W-1:0]  reg_wr_sel_in,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] wb_nextPC,
  output logic [SEL_W-1:0]  wb_reg_sel,
  output logic              wb_reg_write,
  output logic              wb_jr,
  output logic              wb_dump,
  output logic              err
);
  import mem_stage_ctrl_pkg::*;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_d;
  logic             bubble;
  logic             req_raw, stall_raw;
  logic             mem_op;
  logic [DATA_W-1:0] retire_data;

  assign mem_op      = mem_to_reg_in | mem_write_in;
  assign retire_data = mem_to_reg_in ? mem_rdata : result_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err     <= err_d;
    end
  end

  // Next state; every cycle either retires into MEM/WB or inserts a bubble.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err;
    bubble    = 1'b1;
    req_raw   = 1'b0;
    stall_raw = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          if (!result_in[0]) begin
            req_raw = 1'b1;
            if (mem_ready) begin
              bubble = 1'b0;
              if (dump_in) state_d = HALT;
            end else begin
              stall_raw = 1'b1;
              cnt_d     = '0;
              state_d   = ACCESS;
            end
          end else begin
            err_d     = 1'b1;
            stall_raw = 1'b1;
            state_d   = HALT;
          end
        end else begin
          bubble = 1'b0;
          if (dump_in) state_d = HALT;
        end
      end
      ACCESS: begin
        req_raw   = 1'b1;
        stall_raw = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (mem_ready) begin
          stall_raw = 1'b0;
          bubble    = 1'b0;
          cnt_d     = '0;
          state_d   = dump_in ? HALT : IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = HALT;
        end
      end
      HALT: stall_raw = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // Request and stall drop immediately when reset is asserted.
  assign mem_req   = req_raw & rst_n;
  assign stall     = stall_raw & rst_n;
  assign mem_wr    = mem_req & mem_write_in;
  assign mem_addr  = mem_req ? result_in : '0;
  assign mem_wdata = mem_wr ? B_in : '0;

  mem_wb_reg #(
    .DATA_W(DATA_W),
    .SEL_W (SEL_W)
  ) u_mem_wb_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .bubble      (bubble),
    .data        (retire_data),
    .next_pc     (nextPC_in),
    .reg_sel     (reg_wr_sel_in),
    .reg_write   (reg_write_in),
    .jr          (jr_in),
    .dump        (dump_in),
    .wb_data     (wb_data),
    .wb_nextPC   (wb_nextPC),
    .wb_reg_sel  (wb_reg_sel),
    .wb_reg_write(wb_reg_write),
    .wb_jr       (wb_jr),
    .wb_dump     (wb_dump)
  );

endmodule
